// File: rtl/pipe_checker.sv
// Response monitor for pipelined datapaths: queues expected results, checks each
// observed result against the oldest one, and keeps counters, a first-mismatch capture and error flags.
module pipe_checker #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 8,
    parameter int CWIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear_i,
    input  logic                      push_valid_i,
    input  logic [DWIDTH-1:0]         push_exp_i,
    input  logic                      obs_valid_i,
    input  logic [DWIDTH-1:0]         obs_i,
    output logic [$clog2(DEPTH):0]    level_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [CWIDTH-1:0]         pass_cnt_o,
    output logic [CWIDTH-1:0]         fail_cnt_o,
    output logic [1:0]                state_o,
    output logic                      mism_valid_o,
    output logic [DWIDTH-1:0]         mism_exp_o,
    output logic [DWIDTH-1:0]         mism_got_o,
    output logic                      overflow_o,
    output logic                      underflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PASSING = 2'd1,
        ST_FAILED  = 2'd2
    } state_e;

    typedef struct packed {
        logic [AW-1:0]     wr_ptr;
        logic [AW-1:0]     rd_ptr;
        logic [LW-1:0]     level;
        logic [CWIDTH-1:0] pass_cnt;
        logic [CWIDTH-1:0] fail_cnt;
        logic              mism_valid;
        logic [DWIDTH-1:0] mism_exp;
        logic [DWIDTH-1:0] mism_got;
        logic              overflow;
        logic              underflow;
    } regs_t;

    regs_t             regs_q, regs_d;
    state_e            state_q;
    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [DWIDTH-1:0] head;
    logic              is_empty, is_full, pop, push_ok, ovf_evt, unf_evt, hit, miss;

    always_comb begin
        is_empty = (regs_q.level == '0);
        is_full  = (regs_q.level == LW'(DEPTH));
        head     = mem_q[regs_q.rd_ptr];
        pop      = obs_valid_i && !is_empty;
        // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
        push_ok  = push_valid_i && (!is_full || pop);
        ovf_evt  = push_valid_i && is_full && !pop;
        unf_evt  = obs_valid_i && is_empty;
        hit      = pop && (obs_i === head);
        miss     = pop && !hit;
    end

    always_comb begin
        // NOTE: start from the current value so every field has an assignment on every path and no latch is inferred.
        regs_d = regs_q;
        if (push_ok) regs_d.wr_ptr = regs_q.wr_ptr + AW'(1);
        if (pop)     regs_d.rd_ptr = regs_q.rd_ptr + AW'(1);
        case ({push_ok, pop})
            2'b10:   regs_d.level = regs_q.level + LW'(1);
            2'b01:   regs_d.level = regs_q.level - LW'(1);
            default: regs_d.level = regs_q.level;
        endcase
        if (hit && (regs_q.pass_cnt != '1)) regs_d.pass_cnt = regs_q.pass_cnt + CWIDTH'(1);
        if (miss && (regs_q.fail_cnt != '1)) regs_d.fail_cnt = regs_q.fail_cnt + CWIDTH'(1);
        if (miss && !regs_q.mism_valid) begin
            regs_d.mism_valid = 1'b1;
            regs_d.mism_exp   = head;
            regs_d.mism_got   = obs_i;
        end
        regs_d.overflow  = regs_q.overflow  || ovf_evt;
        regs_d.underflow = regs_q.underflow || unf_evt;
        if (clear_i) regs_d = '0;
    end

    // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) regs_q <= '0;
        else      regs_q <= regs_d;
    end

    // NOTE: the storage array has no reset; the pointers and level alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok && !clear_i) mem_q[regs_q.wr_ptr] <= push_exp_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else if (clear_i) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_PASSING: begin
                    if (miss || ovf_evt || unf_evt) state_q <= ST_FAILED;
                    else if (hit)                   state_q <= ST_PASSING;
                end
                ST_FAILED: state_q <= ST_FAILED;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    assign level_o      = regs_q.level;
    assign full_o       = (regs_q.level == LW'(DEPTH));
    assign empty_o      = (regs_q.level == '0);
    assign pass_cnt_o   = regs_q.pass_cnt;
    assign fail_cnt_o   = regs_q.fail_cnt;
    assign state_o      = state_q;
    assign mism_valid_o = regs_q.mism_valid;
    assign mism_exp_o   = regs_q.mism_exp;
    assign mism_got_o   = regs_q.mism_got;
    assign overflow_o   = regs_q.overflow;
    assign underflow_o  = regs_q.underflow;
endmodule
